// File: rtl/pc_unit_if.sv
// Fetch/redirect bundle between the core and the program-counter unit.
// The master side is the core (control, immediates, fetch ready); the slave is pc_unit.
interface pc_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic [1:0]      pc_src;
   logic [XLEN-1:0] imm_op;
   logic [XLEN-1:0] rs1_val;
   logic            trap_req;
   logic            halt;
   logic            fetch_ready;
   logic            fetch_valid;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign;
   logic [XLEN-1:0] bad_addr;

   modport master (
      output stall, pc_src, imm_op, rs1_val, trap_req, halt, fetch_ready,
      input  fetch_valid, pc_out, pc_plus4, misalign, bad_addr
   );

   modport slave (
      input  stall, pc_src, imm_op, rs1_val, trap_req, halt, fetch_ready,
      output fetch_valid, pc_out, pc_plus4, misalign, bad_addr
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: boot delay, fetch handshake, PC-relative/JALR redirects,
// misaligned-target trapping and a halt state.
module pc_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = '0,
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
   parameter int unsigned     IALIGN      = 4,
   parameter int unsigned     BOOT_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);

   localparam int unsigned CW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StHalt
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   boot_cnt_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] bad_addr_q;
   logic            misalign_q;

   logic            is_redirect;
   logic [XLEN-1:0] rel_target;
   logic [XLEN-1:0] jalr_target;
   logic [XLEN-1:0] target;
   logic            target_mis;

   always_comb begin
      rel_target  = pc_q + bus.imm_op;
      jalr_target = (bus.rs1_val + bus.imm_op) & JALR_MASK;
      is_redirect = (bus.pc_src == 2'b01) || (bus.pc_src == 2'b10);
      target      = (bus.pc_src == 2'b10) ? jalr_target : rel_target;
      target_mis  = (IALIGN == 2) ? target[0] : (target[1:0] != 2'b00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         boot_cnt_q <= '0;
         pc_q       <= RESET_VEC;
         bad_addr_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         unique case (state_q)
            StBoot: begin
               if (boot_cnt_q == CW'(BOOT_CYCLES)) begin
                  state_q <= StRun;
               end else begin
                  boot_cnt_q <= boot_cnt_q + 1'b1;
               end
            end
            StRun: begin
               if (bus.trap_req) begin
                  pc_q <= TRAP_VEC;
               end else if (bus.halt) begin
                  state_q <= StHalt;
               end else if (bus.stall) begin
                  pc_q <= pc_q;
               end else if (is_redirect) begin
                  // Redirects abandon any outstanding request, so fetch_ready is not consulted.
                  if (target_mis) begin
                     pc_q       <= TRAP_VEC;
                     bad_addr_q <= target;
                     misalign_q <= 1'b1;
                  end else begin
                     pc_q <= target;
                  end
               end else if (bus.fetch_ready) begin
                  pc_q <= pc_q + XLEN'(4);
               end
            end
            StHalt: begin
               if (bus.trap_req) begin
                  pc_q    <= TRAP_VEC;
                  state_q <= StRun;
               end
            end
            default: state_q <= StBoot;
         endcase
      end
   end

   assign bus.fetch_valid = (state_q == StRun);
   assign bus.pc_out      = pc_q;
   assign bus.pc_plus4    = pc_q + XLEN'(4);
   assign bus.misalign    = misalign_q;
   assign bus.bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table on an IALIGN=4/BOOT_CYCLES=2 instance,
// plus hand sequences for async reset and an IALIGN=2/BOOT_CYCLES=0 instance.
module tb_pc_unit;

   typedef struct {
      logic        stall;
      logic [1:0]  pc_src;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        trap;
      logic        halt;
      logic        ready;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_mis;
      logic [31:0] exp_bad;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   vec_t vq[$];

   pc_unit_if #(.XLEN(32)) a_if ();
   pc_unit_if #(.XLEN(32)) b_if ();

   pc_unit #(
      .XLEN        (32),
      .RESET_VEC   (32'h0),
      .TRAP_VEC    (32'h100),
      .IALIGN      (4),
      .BOOT_CYCLES (2)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   pc_unit #(
      .XLEN        (32),
      .RESET_VEC   (32'h0),
      .TRAP_VEC    (32'h100),
      .IALIGN      (2),
      .BOOT_CYCLES (0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [1:0] src, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic trap, input logic halt,
                               input logic rdy, input logic [31:0] epc, input logic ev,
                               input logic em, input logic [31:0] eb);
      vec_t v;
      v.stall = st;  v.pc_src = src; v.imm = imm; v.rs1 = rs1;
      v.trap = trap; v.halt = halt;  v.ready = rdy;
      v.exp_pc = epc; v.exp_valid = ev; v.exp_mis = em; v.exp_bad = eb;
      return v;
   endfunction

   task automatic drive_b(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs1);
      b_if.stall = 1'b0; b_if.pc_src = src; b_if.imm_op = imm; b_if.rs1_val = rs1;
      b_if.trap_req = 1'b0; b_if.halt = 1'b0; b_if.fetch_ready = 1'b1;
   endtask

   task automatic check_b(input string tag, input logic [31:0] epc, input logic ev,
                          input logic em, input logic [31:0] eb);
      check({tag, " b.pc"}, b_if.pc_out, epc);
      check({tag, " b.valid"}, {31'b0, b_if.fetch_valid}, {31'b0, ev});
      check({tag, " b.mis"}, {31'b0, b_if.misalign}, {31'b0, em});
      check({tag, " b.bad"}, b_if.bad_addr, eb);
   endtask

   initial begin
      tests = 0;
      fails = 0;

      //                st  src    imm            rs1           tr hl rd  exp_pc         v  m  bad
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h0,         0, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h0,         0, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h0,         1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h4,         1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h8,         1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'hC,         1, 0, 32'h0));
      vq.push_back(mk(0, 2'b10, 32'h0,         32'h10,        0, 0, 1, 32'h10,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 0, 32'h10,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 0, 32'h10,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 0, 32'h10,        1, 0, 32'h0));
      vq.push_back(mk(1, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h10,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h14,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b01, 32'hC,         32'h0,         0, 0, 1, 32'h20,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b01, 32'hFFFF_FFF8, 32'h0,         0, 0, 1, 32'h18,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b10, 32'h4,         32'h1001,      0, 0, 1, 32'h1004,      1, 0, 32'h0));
      vq.push_back(mk(0, 2'b10, 32'h0,         32'h40,        0, 0, 1, 32'h40,        1, 0, 32'h0));
      vq.push_back(mk(0, 2'b01, 32'h6,         32'h0,         0, 0, 1, 32'h100,       1, 1, 32'h46));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h104,       1, 0, 32'h46));
      vq.push_back(mk(0, 2'b11, 32'h80,        32'h0,         0, 0, 1, 32'h108,       1, 0, 32'h46));
      vq.push_back(mk(0, 2'b01, 32'h40,        32'h0,         0, 1, 1, 32'h108,       0, 0, 32'h46));
      vq.push_back(mk(0, 2'b01, 32'h40,        32'h0,         0, 0, 1, 32'h108,       0, 0, 32'h46));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 1, 1, 32'h108,       0, 0, 32'h46));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         1, 0, 1, 32'h100,       1, 0, 32'h46));
      vq.push_back(mk(1, 2'b00, 32'h0,         32'h0,         1, 0, 1, 32'h100,       1, 0, 32'h46));
      vq.push_back(mk(0, 2'b01, 32'h2,         32'h0,         1, 0, 1, 32'h100,       1, 0, 32'h46));
      vq.push_back(mk(0, 2'b10, 32'h0,         32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h46));
      vq.push_back(mk(0, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h0,         1, 0, 32'h46));
      vq.push_back(mk(0, 2'b01, 32'h30,        32'h0,         0, 0, 0, 32'h30,        1, 0, 32'h46));
      vq.push_back(mk(0, 2'b10, 32'h0,         32'h203,       0, 0, 1, 32'h100,       1, 1, 32'h202));

      a_if.stall = 1'b0; a_if.pc_src = 2'b00; a_if.imm_op = '0; a_if.rs1_val = '0;
      a_if.trap_req = 1'b0; a_if.halt = 1'b0; a_if.fetch_ready = 1'b1;
      drive_b(2'b00, 32'h0, 32'h0);

      rst = 1'b1;
      #12;
      check("reset a.pc", a_if.pc_out, 32'h0);
      check("reset a.valid", {31'b0, a_if.fetch_valid}, 32'h0);
      check("reset a.mis", {31'b0, a_if.misalign}, 32'h0);
      check("reset a.bad", a_if.bad_addr, 32'h0);
      check("reset a.plus4", a_if.pc_plus4, 32'h4);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         a_if.stall = vq[i].stall;  a_if.pc_src = vq[i].pc_src;
         a_if.imm_op = vq[i].imm;   a_if.rs1_val = vq[i].rs1;
         a_if.trap_req = vq[i].trap; a_if.halt = vq[i].halt;
         a_if.fetch_ready = vq[i].ready;
         @(posedge clk);
         #1;
         check($sformatf("v%0d pc", i), a_if.pc_out, vq[i].exp_pc);
         check($sformatf("v%0d valid", i), {31'b0, a_if.fetch_valid}, {31'b0, vq[i].exp_valid});
         check($sformatf("v%0d mis", i), {31'b0, a_if.misalign}, {31'b0, vq[i].exp_mis});
         check($sformatf("v%0d bad", i), a_if.bad_addr, vq[i].exp_bad);
         check($sformatf("v%0d plus4", i), a_if.pc_plus4, vq[i].exp_pc + 32'h4);
      end

      // Asynchronous reset between edges, while A is in RUN with misalign and bad_addr set.
      a_if.pc_src = 2'b00; a_if.fetch_ready = 1'b1;
      rst = 1'b1;
      #2;
      check("async a.pc", a_if.pc_out, 32'h0);
      check("async a.valid", {31'b0, a_if.fetch_valid}, 32'h0);
      check("async a.mis", {31'b0, a_if.misalign}, 32'h0);
      check("async a.bad", a_if.bad_addr, 32'h0);
      check_b("async", 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // IALIGN=2, BOOT_CYCLES=0: RUN on the first edge after release.
      drive_b(2'b00, 32'h0, 32'h0);
      b_if.fetch_ready = 1'b0;
      @(posedge clk); #1;
      check_b("boot0", 32'h0, 1'b1, 1'b0, 32'h0);
      drive_b(2'b01, 32'h40, 32'h0);
      @(posedge clk); #1;
      check_b("rel40", 32'h40, 1'b1, 1'b0, 32'h0);
      drive_b(2'b01, 32'h6, 32'h0);
      @(posedge clk); #1;
      check_b("half46", 32'h46, 1'b1, 1'b0, 32'h0);
      drive_b(2'b10, 32'h0, 32'h47);
      @(posedge clk); #1;
      check_b("jalr47", 32'h46, 1'b1, 1'b0, 32'h0);
      drive_b(2'b01, 32'h1, 32'h0);
      @(posedge clk); #1;
      check_b("odd47", 32'h100, 1'b1, 1'b1, 32'h47);
      drive_b(2'b00, 32'h0, 32'h0);
      @(posedge clk); #1;
      check_b("pulse", 32'h104, 1'b1, 1'b0, 32'h47);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
